fixed_point_divider: RTL and testbench



---
 rtl/jpeg2k_fixed_pkg.sv | 23 ++
 rtl/fixed_point_divider.sv | 216 +++++++++++++++++++++
 tb/tb_fixed_point_divider.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/jpeg2k_fixed_pkg.sv
// Shared fixed-point helpers for the JPEG2000 datapath: saturation bounds,
// fixed-to-real conversion for simulation messages, and the divider state enum.
package jpeg2k_fixed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    function automatic real fx_to_real(input longint value, input int point);
        return real'(value) / (2.0 ** point);
    endfunction

endpackage

// File: rtl/fixed_point_divider.sv
// Iterative signed fixed-point divider: radix-2 restoring division on operand
// magnitudes, one quotient bit per clock, result saturated to the output format.
module fixed_point_divider
    import jpeg2k_fixed_pkg::*;
#(
    parameter int AWidth   = 16,
    parameter int APoint   = 10,
    parameter int BWidth   = 16,
    parameter int BPoint   = 10,
    parameter int OutWidth = 16,
    parameter int OutPoint = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic signed [AWidth-1:0]   a_i,
    input  logic signed [BWidth-1:0]   b_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic signed [OutWidth-1:0] q_o,
    output logic                       ovf_o,
    output logic                       dz_o
);

    localparam int S    = OutPoint + BPoint - APoint;
    localparam int SU   = (S < 0) ? 0 : S;
    localparam int DW   = AWidth + SU;
    localparam int CntW = $clog2(DW + 1);
    localparam int CW   = ((DW > OutWidth) ? DW : OutWidth) + 1;

    generate
        if (S < 0) begin : g_bad_scale
            $error("fixed_point_divider: OutPoint + BPoint - APoint must be >= 0");
        end
    endgenerate

    div_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [DW-1:0]     dq_q;
    logic [BWidth:0]   rem_q;
    logic [BWidth-1:0] bmag_q;
    logic              neg_q;
    logic              a_neg_q;
    logic              a_zero_q;
    logic              b_zero_q;

    logic signed [OutWidth-1:0] q_q, q_d;
    logic                       ovf_q, ovf_d;
    logic                       dz_q, dz_d;

    logic              accept;
    logic              finish;
    logic [AWidth-1:0] amag;
    logic [BWidth-1:0] bmag;
    logic [BWidth:0]   rem_sh;
    logic [BWidth:0]   rem_sub;
    logic              step_bit;

    function automatic logic signed [OutWidth-1:0] saturate(
        input  logic [DW-1:0] mag,
        input  logic          neg,
        output logic          ovf
    );
        logic [CW-1:0]              magx;
        logic [CW-1:0]              pos_lim;
        logic [CW-1:0]              neg_lim;
        logic signed [OutWidth-1:0] qs;
        magx    = CW'(mag);
        pos_lim = (CW'(1) << (OutWidth - 1)) - CW'(1);
        neg_lim = CW'(1) << (OutWidth - 1);
        qs      = OutWidth'(mag);
        ovf     = 1'b0;
        if (!neg && (magx > pos_lim)) begin
            ovf = 1'b1;
            qs  = OutWidth'(sat_max(OutWidth));
        end else if (neg && (magx > neg_lim)) begin
            ovf = 1'b1;
            qs  = OutWidth'(sat_min(OutWidth));
        end else if (neg) begin
            qs = -qs;
        end
        return qs;
    endfunction

    function automatic logic signed [OutWidth-1:0] div_zero_result(
        input logic a_neg,
        input logic a_zero
    );
        logic signed [OutWidth-1:0] qs;
        if (a_zero) begin
            qs = '0;
        end else if (a_neg) begin
            qs = OutWidth'(sat_min(OutWidth));
        end else begin
            qs = OutWidth'(sat_max(OutWidth));
        end
        return qs;
    endfunction

    // Magnitudes are unsigned so the most negative operand is exact.
    assign amag = a_i[AWidth-1] ? $unsigned(-a_i) : $unsigned(a_i);
    assign bmag = b_i[BWidth-1] ? $unsigned(-b_i) : $unsigned(b_i);

    assign accept = s_valid_i & s_ready_o;
    assign finish = (state_q == CALC) && (cnt_q == '0);

    assign rem_sh   = {rem_q[BWidth-1:0], dq_q[DW-1]};
    assign rem_sub  = rem_sh - {1'b0, bmag_q};
    assign step_bit = (rem_sh >= {1'b0, bmag_q});

    // Dividend bits shift out at the top while quotient bits shift in at the bottom.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            dq_q     <= DW'(amag) << SU;
            rem_q    <= '0;
            bmag_q   <= bmag;
            neg_q    <= a_i[AWidth-1] ^ b_i[BWidth-1];
            a_neg_q  <= a_i[AWidth-1];
            a_zero_q <= (a_i == '0);
            b_zero_q <= (b_i == '0);
        end else if ((state_q == CALC) && (cnt_q != '0)) begin
            dq_q  <= {dq_q[DW-2:0], step_bit};
            rem_q <= step_bit ? rem_sub : rem_sh;
        end
    end

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        dz_d  = dz_q;
        if (finish) begin
            if (b_zero_q) begin
                q_d   = div_zero_result(a_neg_q, a_zero_q);
                ovf_d = 1'b0;
                dz_d  = 1'b1;
            end else begin
                q_d  = saturate(dq_q, neg_q, ovf_d);
                dz_d = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = CntW'(DW);
        end else if ((state_q == CALC) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_valid_i) state_d = CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (m_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready_o = 1'b0;
        m_valid_o = 1'b0;
        case (state_q)
            IDLE:    s_ready_o = 1'b1;
            DONE:    m_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign q_o   = q_q;
    assign ovf_o = ovf_q;
    assign dz_o  = dz_q;

`ifndef SYNTHESIS
    logic signed [AWidth-1:0] a_raw_q;
    logic signed [BWidth-1:0] b_raw_q;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            a_raw_q <= a_i;
            b_raw_q <= b_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (m_valid_o && m_ready_i && (ovf_q || dz_q)) begin
            $display("fixed_point_divider: %s a=%f b=%f q=%f",
                     dz_q ? "divide-by-zero" : "saturated",
                     fx_to_real(longint'(a_raw_q), APoint),
                     fx_to_real(longint'(b_raw_q), BPoint),
                     fx_to_real(longint'(q_q), OutPoint));
        end
    end
`endif

endmodule

// File: tb/tb_fixed_point_divider.sv
// Bench for fixed_point_divider: directed and random operands against an
// arithmetic reference, with latency, backpressure and reset checks.
module tb_fixed_point_divider;

    localparam int AW = 16, AP = 10, BW = 16, BP = 10, OW = 16, OP = 10;
    localparam int S  = OP + BP - AP;
    localparam int LAT = AW + S + 1;

    logic                 clk_i = 1'b0;
    logic                 rst_n_i = 1'b0;
    logic                 s_valid_i = 1'b0;
    logic                 s_ready_o;
    logic signed [AW-1:0] a_i = '0;
    logic signed [BW-1:0] b_i = '0;
    logic                 m_valid_o;
    logic                 m_ready_i = 1'b0;
    logic signed [OW-1:0] q_o;
    logic                 ovf_o;
    logic                 dz_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    fixed_point_divider #(
        .AWidth(AW), .APoint(AP), .BWidth(BW), .BPoint(BP),
        .OutWidth(OW), .OutPoint(OP)
    ) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i),
        .q_o      (q_o),
        .ovf_o    (ovf_o),
        .dz_o     (dz_o)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic void model(input longint a, input longint b,
                                  output longint q, output bit ovf, output bit dz);
        longint maxp, minn, mag;
        bit     neg;
        maxp = (longint'(1) << (OW - 1)) - 1;
        minn = -(longint'(1) << (OW - 1));
        ovf  = 0;
        dz   = 0;
        if (b == 0) begin
            dz = 1;
            q  = (a > 0) ? maxp : ((a < 0) ? minn : 0);
        end else begin
            neg = (a < 0) != (b < 0);
            mag = ((a < 0 ? -a : a) * (longint'(1) << S)) / (b < 0 ? -b : b);
            if (!neg && mag > maxp) begin
                q = maxp; ovf = 1;
            end else if (neg && mag > -minn) begin
                q = minn; ovf = 1;
            end else begin
                q = neg ? -mag : mag;
            end
        end
    endfunction

    // Called at #1 after a posedge with the DUT idle.
    task automatic run_op(input longint a, input longint b, input int hold,
                          input bit noise, input string tag);
        longint eq;
        bit     eovf, edz;
        int     lat;
        model(a, b, eq, eovf, edz);
        check({tag, "_ready"}, s_ready_o, 1);
        s_valid_i = 1'b1;
        a_i = AW'(a);
        b_i = BW'(b);
        @(posedge clk_i); #1;
        s_valid_i = 1'b0;
        lat = 0;
        while (!m_valid_o && lat < 100) begin
            if (noise) begin
                s_valid_i = lat[0];
                a_i = AW'($urandom);
                b_i = BW'($urandom);
            end
            @(posedge clk_i); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_q"}, q_o, eq);
        check({tag, "_ovf"}, ovf_o, eovf);
        check({tag, "_dz"}, dz_o, edz);
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                s_valid_i = 1'b1;
                a_i = AW'($urandom);
                b_i = BW'($urandom);
            end
            @(posedge clk_i); #1;
            check({tag, "_hold_valid"}, m_valid_o, 1);
            check({tag, "_hold_sready"}, s_ready_o, 0);
            check({tag, "_hold_q"}, q_o, eq);
            check({tag, "_hold_ovf"}, ovf_o, eovf);
            check({tag, "_hold_dz"}, dz_o, edz);
        end
        m_ready_i = 1'b1;
        @(posedge clk_i); #1;
        m_ready_i = 1'b0;
        s_valid_i = 1'b0;
        check({tag, "_ack_valid"}, m_valid_o, 0);
        check({tag, "_ack_sready"}, s_ready_o, 1);
    endtask

    initial begin
        #3;
        check("rst_sready", s_ready_o, 1);
        check("rst_mvalid", m_valid_o, 0);
        check("rst_q", q_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_dz", dz_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        run_op(3072, 1536, 0, 0, "d_3_over_1p5");
        run_op(-1024, 256, 0, 0, "d_neg1_over_q");
        run_op(1024, 3072, 0, 0, "d_trunc_pos");
        run_op(-1024, 3072, 0, 0, "d_trunc_neg");
        run_op(31744, 64, 0, 0, "d_sat_pos");
        run_op(-31744, 64, 0, 0, "d_sat_neg");
        run_op(-32768, -1024, 0, 0, "d_sat_minmin");
        run_op(-1024, 0, 0, 0, "d_dz_neg");
        run_op(0, 0, 0, 0, "d_dz_zero");
        run_op(5000, 0, 0, 0, "d_dz_pos");
        run_op(-32768, 1024, 0, 0, "d_min_exact");
        run_op(1000, -3000, 5, 1, "d_backpressure");

        for (int k = 0; k < 30; k++) begin
            longint ra, rb;
            ra = longint'($signed(16'($urandom)));
            case ($urandom_range(0, 7))
                0:       rb = 0;
                1, 2:    rb = longint'($urandom_range(0, 128)) - 64;
                default: rb = longint'($signed(16'($urandom)));
            endcase
            if ($urandom_range(0, 3) == 0) ra = longint'($urandom_range(0, 2048)) - 1024;
            run_op(ra, rb, $urandom_range(0, 3), k[0], "rand");
        end

        run_op(3072, 1536, 0, 0, "pre_reset");
        s_valid_i = 1'b1;
        a_i = 16'sd7000;
        b_i = 16'sd300;
        @(posedge clk_i); #1;
        s_valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        check("midreset_sready", s_ready_o, 1);
        check("midreset_mvalid", m_valid_o, 0);
        check("midreset_q", q_o, 0);
        check("midreset_ovf", ovf_o, 0);
        check("midreset_dz", dz_o, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        run_op(2048, 1024, 0, 0, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
